// File: rtl/pipeline_elastic_stage_pkg.sv
// pipeline_elastic_stage_pkg: shared widths, clog2 helper, default bubble and ID/EX bundle layout
package pipeline_elastic_stage_pkg;
  localparam int WORD_W  = 32;
  localparam int FUNCT_W = 6;
  localparam int SHAMT_W = 5;
  localparam int REG_W   = 5;
  localparam logic [WORD_W-1:0] BUBBLE_DEFAULT = '0;
  typedef struct packed {
    logic [FUNCT_W-1:0] funct;
    logic [SHAMT_W-1:0] shamt;
    logic [WORD_W-1:0]  op_a;
    logic [WORD_W-1:0]  op_b;
    logic               mem_rd;
    logic               mem_wr;
    logic [REG_W-1:0]   rd_addr;
    logic               reg_wr;
    logic               cp_wr;
    logic               exc_ovf;
    logic               exc_sys;
  } idex_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/pipeline_elastic_stage.sv
// pipeline_elastic_stage: DEPTH-entry elastic buffer between pipeline stages with valid/ready, flush and bubble output
// Ports: clk, rst (async, active-low), flush (sync kill), in_valid/in_ready/in_data (producer side),
//        out_valid/out_ready/out_data (consumer side), level (registered occupancy)
module pipeline_elastic_stage
  import pipeline_elastic_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] BUBBLE = DATA_WIDTH'(BUBBLE_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [clog2(DEPTH+1)-1:0]    level
);
  localparam int LW = clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? clog2(DEPTH) : 1;
  localparam logic [LW-1:0] C_ONE = LW'(1);
  localparam logic [LW-1:0] C_DEPTH = LW'(DEPTH);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [LW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic in_ready_q, in_ready_d;
  logic push, pop;
  always_comb begin
    push = in_valid & in_ready_q & ~flush;
    pop = out_valid & out_ready & ~flush;
    // explicit wrap so non-power-of-two depths never index past the last entry
    wr_ptr_d = flush ? '0 : push ? (wr_ptr_q == P_LAST ? '0 : wr_ptr_q + P_ONE) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : pop ? (rd_ptr_q == P_LAST ? '0 : rd_ptr_q + P_ONE) : rd_ptr_q;
    count_d = flush ? '0 : (push & ~pop) ? count_q + C_ONE : (pop & ~push) ? count_q - C_ONE : count_q;
    // ready looks at next occupancy so it is a flop with no path from out_ready
    in_ready_d = count_d < C_DEPTH;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      in_ready_q <= in_ready_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_data;
  assign out_valid = count_q != '0;
  assign out_data = out_valid ? mem_q[rd_ptr_q] : BUBBLE;
  assign in_ready = in_ready_q;
  assign level = count_q;
endmodule

// File: tb/tb_pipeline_elastic_stage.sv
// tb_pipeline_elastic_stage: directed checks of the elastic stage at DEPTH=2 and DEPTH=3
module tb_pipeline_elastic_stage;
  logic clk, rst;
  logic a_flush, a_valid, a_in_ready, a_out_valid, a_rdy;
  logic [7:0] a_data, a_out_data;
  logic [1:0] a_level;
  logic b_flush, b_valid, b_in_ready, b_out_valid, b_rdy;
  logic [7:0] b_data, b_out_data;
  logic [1:0] b_level;
  int n_pass = 0, n_total = 0;
  pipeline_elastic_stage #(.DATA_WIDTH(8), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_valid), .in_ready(a_in_ready),
    .in_data(a_data), .out_valid(a_out_valid), .out_ready(a_rdy), .out_data(a_out_data), .level(a_level));
  pipeline_elastic_stage #(.DATA_WIDTH(8), .DEPTH(3), .BUBBLE(8'hEE)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_valid), .in_ready(b_in_ready),
    .in_data(b_data), .out_valid(b_out_valid), .out_ready(b_rdy), .out_data(b_out_data), .level(b_level));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic [1:0] l, input logic r);
    chk({tag, "_valid"}, a_out_valid, v);
    chk({tag, "_data"}, a_out_data, d);
    chk({tag, "_level"}, a_level, l);
    chk({tag, "_ready"}, a_in_ready, r);
  endtask
  initial begin
    logic [7:0] stream [3];
    int sent, got, cnt, pw, pp;
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33;
    {a_flush, a_valid, a_rdy, a_data} = '0;
    {b_flush, b_valid, b_rdy, b_data} = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 chk_a("rst_async", 0, 8'h00, 0, 0);
    repeat (3) @(posedge clk);
    #1 chk_a("rst_held", 0, 8'h00, 0, 0);
    chk("rst_b_data", b_out_data, 8'hEE);
    chk("rst_b_ready", b_in_ready, 0);
    rst = 1'b1;
    #2 chk("rel_ready_pre_edge", a_in_ready, 0);
    step();
    chk_a("rel", 0, 8'h00, 0, 1);
    // streaming with consumer always ready
    a_rdy = 1'b1;
    a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_data = stream[i];
      step();
      chk_a("stream", 1, stream[i], 1, 1);
    end
    a_valid = 1'b0;
    step();
    chk_a("stream_drain", 0, 8'h00, 0, 1);
    // backpressure
    a_rdy = 1'b0;
    a_valid = 1'b1;
    a_data = 8'hA1;
    step();
    chk_a("bp1", 1, 8'hA1, 1, 1);
    a_data = 8'hA2;
    step();
    chk_a("bp_full", 1, 8'hA1, 2, 0);
    a_data = 8'hA3;
    step();
    chk_a("bp_hold", 1, 8'hA1, 2, 0);
    a_rdy = 1'b1;
    step();
    chk_a("bp_pop1", 1, 8'hA2, 1, 1);
    step();
    chk_a("bp_pop2", 1, 8'hA3, 1, 1);
    a_valid = 1'b0;
    step();
    chk_a("bp_drain", 0, 8'h00, 0, 1);
    // flush while full with a pop and an offer pending
    a_rdy = 1'b0;
    a_valid = 1'b1;
    a_data = 8'hB1;
    step();
    a_data = 8'hB2;
    step();
    chk_a("fl_pre", 1, 8'hB1, 2, 0);
    a_flush = 1'b1;
    a_rdy = 1'b1;
    a_data = 8'h55;
    step();
    chk_a("fl_full", 0, 8'h00, 0, 1);
    step();
    chk_a("fl_held", 0, 8'h00, 0, 1);
    a_flush = 1'b0;
    a_valid = 1'b0;
    step();
    chk_a("fl_after", 0, 8'h00, 0, 1);
    // flush with in_ready high must still discard the push
    a_rdy = 1'b0;
    a_valid = 1'b1;
    a_data = 8'hC1;
    step();
    a_flush = 1'b1;
    a_data = 8'h55;
    step();
    a_flush = 1'b0;
    a_valid = 1'b0;
    chk_a("fl_push", 0, 8'h00, 0, 1);
    // pointers restart at 0 after flush: next entry comes out in order
    a_valid = 1'b1;
    a_data = 8'hC2;
    step();
    a_data = 8'hC3;
    step();
    a_valid = 1'b0;
    a_rdy = 1'b1;
    chk_a("fl_reuse1", 1, 8'hC2, 2, 0);
    step();
    chk_a("fl_reuse2", 1, 8'hC3, 1, 1);
    step();
    // asynchronous reset between edges with level=2
    a_rdy = 1'b0;
    a_valid = 1'b1;
    a_data = 8'hD1;
    step();
    a_data = 8'hD2;
    step();
    a_valid = 1'b0;
    chk_a("ar_pre", 1, 8'hD1, 2, 0);
    #2 rst = 1'b0;
    #1 chk_a("ar_now", 0, 8'h00, 0, 0);
    #2 rst = 1'b1;
    step();
    chk_a("ar_rel", 0, 8'h00, 0, 1);
    a_rdy = 1'b1;
    a_valid = 1'b1;
    a_data = 8'hD3;
    step();
    a_valid = 1'b0;
    chk_a("ar_fresh", 1, 8'hD3, 1, 1);
    step();
    chk_a("ar_end", 0, 8'h00, 0, 1);
    // DEPTH=3 wrap-around with random consumer readiness
    sent = 0; got = 0; cnt = 0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      b_valid = sent < 10;
      b_data = 8'(sent + 1);
      b_rdy = cyc < 12 ? (cyc % 4 == 3) : 1'($urandom % 2);
      pw = int'(b_valid && b_in_ready);
      pp = int'(b_out_valid && b_rdy);
      chk("wrap_level", b_level, cnt);
      chk("wrap_ready", b_in_ready, cnt < 3);
      if (pp != 0) begin
        chk("wrap_data", b_out_data, got + 1);
        got++;
      end
      step();
      sent += pw;
      cnt += pw - pp;
    end
    b_valid = 1'b0;
    chk("wrap_all", got, 10);
    chk("wrap_empty_valid", b_out_valid, 0);
    chk("wrap_bubble", b_out_data, 8'hEE);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
